// File: rtl/calc_pkg.sv
// Shared token codes, error codes, FSM states and operator encoding for the stack calculator.
package calc_pkg;

    localparam logic [3:0] TOK_ADD   = 4'hA;
    localparam logic [3:0] TOK_SUB   = 4'hB;
    localparam logic [3:0] TOK_MUL   = 4'hC;
    localparam logic [3:0] TOK_DIV   = 4'hD;
    localparam logic [3:0] TOK_ENTER = 4'hE;
    localparam logic [3:0] TOK_CLR   = 4'hF;

    localparam logic [1:0] ERR_NONE      = 2'b00;
    localparam logic [1:0] ERR_OVERFLOW  = 2'b01;
    localparam logic [1:0] ERR_UNDERFLOW = 2'b10;
    localparam logic [1:0] ERR_DIV_ZERO  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PUSH,
        ST_EXEC,
        ST_DIV_WAIT,
        ST_WRITE,
        ST_ERROR
    } state_e;

    typedef enum logic [1:0] {
        OP_ADD,
        OP_SUB,
        OP_MUL,
        OP_DIV
    } op_e;

    function automatic op_e tok_to_op(input logic [3:0] tok);
        case (tok)
            TOK_SUB: return OP_SUB;
            TOK_MUL: return OP_MUL;
            TOK_DIV: return OP_DIV;
            default: return OP_ADD;
        endcase
    endfunction

endpackage

// File: rtl/calc_divider.sv
// Radix-2 restoring unsigned divider; done pulses exactly WIDTH cycles after start.
module calc_divider #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic             done
);
    localparam int unsigned CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic [WIDTH:0]   rem_t, rem_sub;
    logic             ge;

    always_comb begin
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        rem_t   = {rem_q, quo_q[WIDTH-1]};
        rem_sub = rem_t - {1'b0, dvs_q};
        ge      = (rem_t >= {1'b0, dvs_q});
        if (start) begin
            rem_d  = '0;
            quo_d  = dividend;
            dvs_d  = divisor;
            cnt_d  = CW'(WIDTH);
            busy_d = 1'b1;
        end else if (busy_q) begin
            rem_d = ge ? rem_sub[WIDTH-1:0] : rem_t[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], ge};
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dvs_q  <= dvs_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign quotient = quo_q;
    assign done     = done_q;

endmodule

// File: rtl/calc_sequencer.sv
// RPN calculator controller: token intake, operand accumulation, operand stack and op sequencing.
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       tok_valid,
    input  logic [3:0]                 tok_data,
    output logic                       tok_ready,
    output logic [WIDTH-1:0]           result,
    output logic                       result_valid,
    output logic                       err,
    output logic [1:0]                 err_code,
    output logic [$clog2(DEPTH+1)-1:0] depth
);
    localparam int unsigned SPW = $clog2(DEPTH + 1);
    localparam int unsigned IW  = $clog2(DEPTH);

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [SPW-1:0]   sp_q, sp_d;
    logic [WIDTH-1:0] acc_q, acc_d, res_q, res_d, result_q, result_d;
    logic [WIDTH-1:0] stack_q [DEPTH];
    logic [WIDTH-1:0] stack_d [DEPTH];
    logic             pending_q, pending_d, result_valid_q, result_valid_d;
    logic             err_q, err_d, tok_ready_q, tok_ready_d;
    logic [1:0]       err_code_q, err_code_d;
    logic             accept, div_start, div_done;
    logic [WIDTH-1:0] a_val, b_val, div_quo;

    assign accept = tok_valid & tok_ready_q;
    assign a_val  = stack_q[IW'(sp_q - SPW'(2))];
    assign b_val  = stack_q[IW'(sp_q - SPW'(1))];

    calc_divider #(.WIDTH(WIDTH)) u_div (
        .clk      (clk),
        .reset    (reset),
        .start    (div_start),
        .dividend (a_val),
        .divisor  (b_val),
        .quotient (div_quo),
        .done     (div_done)
    );

    always_comb begin
        state_d        = state_q;
        op_d           = op_q;
        sp_d           = sp_q;
        acc_d          = acc_q;
        pending_d      = pending_q;
        res_d          = res_q;
        result_d       = result_q;
        result_valid_d = 1'b0;
        err_d          = err_q;
        err_code_d     = err_code_q;
        stack_d        = stack_q;
        div_start      = 1'b0;
        case (state_q)
            ST_IDLE: if (accept) begin
                if (tok_data <= 4'd9) begin
                    acc_d     = acc_q * WIDTH'(10) + WIDTH'(tok_data);
                    pending_d = 1'b1;
                    result_d  = acc_d;
                end else if (tok_data == TOK_CLR) begin
                    sp_d      = '0;
                    acc_d     = '0;
                    pending_d = 1'b0;
                    result_d  = '0;
                    err_d     = 1'b0;
                    err_code_d = ERR_NONE;
                end else if (tok_data == TOK_ENTER) begin
                    if (sp_q == SPW'(DEPTH)) begin
                        err_d      = 1'b1;
                        err_code_d = ERR_OVERFLOW;
                        state_d    = ST_ERROR;
                    end else begin
                        stack_d[IW'(sp_q)] = acc_q;
                        sp_d      = sp_q + SPW'(1);
                        result_d  = acc_q;
                        acc_d     = '0;
                        pending_d = 1'b0;
                    end
                end else begin
                    op_d    = tok_to_op(tok_data);
                    state_d = pending_q ? ST_PUSH : ST_EXEC;
                end
            end
            // Implicit enter of the operand typed before the operator
            ST_PUSH: begin
                if (sp_q == SPW'(DEPTH)) begin
                    err_d      = 1'b1;
                    err_code_d = ERR_OVERFLOW;
                    state_d    = ST_ERROR;
                end else begin
                    stack_d[IW'(sp_q)] = acc_q;
                    sp_d      = sp_q + SPW'(1);
                    result_d  = acc_q;
                    acc_d     = '0;
                    pending_d = 1'b0;
                    state_d   = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (sp_q < SPW'(2)) begin
                    err_d      = 1'b1;
                    err_code_d = ERR_UNDERFLOW;
                    state_d    = ST_ERROR;
                end else begin
                    case (op_q)
                        OP_ADD: begin res_d = a_val + b_val; state_d = ST_WRITE; end
                        OP_SUB: begin res_d = a_val - b_val; state_d = ST_WRITE; end
                        OP_MUL: begin res_d = WIDTH'(a_val * b_val); state_d = ST_WRITE; end
                        default: begin
                            if (b_val == '0) begin
                                err_d      = 1'b1;
                                err_code_d = ERR_DIV_ZERO;
                                state_d    = ST_ERROR;
                            end else begin
                                div_start = 1'b1;
                                state_d   = ST_DIV_WAIT;
                            end
                        end
                    endcase
                end
            end
            ST_DIV_WAIT: if (div_done) begin
                res_d   = div_quo;
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                stack_d[IW'(sp_q - SPW'(2))] = res_q;
                sp_d           = sp_q - SPW'(1);
                result_d       = res_q;
                result_valid_d = 1'b1;
                state_d        = ST_IDLE;
            end
            ST_ERROR: if (accept && tok_data == TOK_CLR) begin
                sp_d       = '0;
                acc_d      = '0;
                pending_d  = 1'b0;
                result_d   = '0;
                err_d      = 1'b0;
                err_code_d = ERR_NONE;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        tok_ready_d = (state_d == ST_IDLE) || (state_d == ST_ERROR);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            op_q           <= OP_ADD;
            sp_q           <= '0;
            acc_q          <= '0;
            pending_q      <= 1'b0;
            res_q          <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            err_q          <= 1'b0;
            err_code_q     <= ERR_NONE;
            tok_ready_q    <= 1'b1;
        end else begin
            state_q        <= state_d;
            op_q           <= op_d;
            sp_q           <= sp_d;
            acc_q          <= acc_d;
            pending_q      <= pending_d;
            res_q          <= res_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            err_q          <= err_d;
            err_code_q     <= err_code_d;
            tok_ready_q    <= tok_ready_d;
        end
    end

    // Stack contents need no reset; sp bounds every read that matters
    always_ff @(posedge clk) begin
        stack_q <= stack_d;
    end

    assign tok_ready    = tok_ready_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign err          = err_q;
    assign err_code     = err_code_q;
    assign depth        = sp_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed self-checking bench for calc_sequencer with hand-computed expectations.
module tb_calc_sequencer;
    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned DW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             reset;
    logic             tok_valid;
    logic [3:0]       tok_data;
    logic             tok_ready;
    logic [WIDTH-1:0] result;
    logic             result_valid;
    logic             err;
    logic [1:0]       err_code;
    logic [DW-1:0]    depth;

    int n_checks = 0;
    int n_fails  = 0;
    int cyc      = 0;
    int acc_cyc  = 0;
    int rv_cyc   = 0;
    int rv_count = 0;

    calc_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .tok_valid    (tok_valid),
        .tok_data     (tok_data),
        .tok_ready    (tok_ready),
        .result       (result),
        .result_valid (result_valid),
        .err          (err),
        .err_code     (err_code),
        .depth        (depth)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (result_valid) begin
            rv_count = rv_count + 1;
            rv_cyc   = cyc;
        end
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic send(input logic [3:0] t);
        int n = 0;
        @(negedge clk);
        while (!tok_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!tok_ready) check("ready_timeout", 64'(tok_ready), 64'd1);
        tok_valid = 1'b1;
        tok_data  = t;
        @(posedge clk);
        #1;
        acc_cyc   = cyc;
        tok_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (!tok_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!tok_ready) check("idle_timeout", 64'(tok_ready), 64'd1);
        #2;
    endtask

    task automatic send_seq(input logic [3:0] seq [$]);
        foreach (seq[i]) send(seq[i]);
        wait_idle();
    endtask

    initial begin
        reset     = 1'b0;
        tok_valid = 1'b0;
        tok_data  = 4'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        check("rst_ready", 64'(tok_ready), 64'd1);
        check("rst_depth", 64'(depth), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_rv", 64'(result_valid), 64'd0);

        // 1: plain digit entry and enter
        rv_count = 0;
        send_seq('{4'h1, 4'h2, 4'h3, 4'hE});
        check("t1_result", 64'(result), 64'd123);
        check("t1_depth", 64'(depth), 64'd1);
        check("t1_rv_none", 64'(rv_count), 64'd0);

        // 2: subtract with implicit push
        rv_count = 0;
        send_seq('{4'hF, 4'h7, 4'hE, 4'h5, 4'hB});
        check("t2_latency", 64'(rv_cyc - acc_cyc), 64'd3);
        check("t2_rv_once", 64'(rv_count), 64'd1);
        check("t2_result", 64'(result), 64'd2);
        check("t2_depth", 64'(depth), 64'd1);

        // 3: divide with implicit push, then wrapping subtract
        send_seq('{4'hF, 4'h1, 4'h0, 4'h0, 4'hE, 4'h7, 4'hD});
        check("t3_div_latency", 64'(rv_cyc - acc_cyc), 64'(WIDTH + 4));
        check("t3_div_result", 64'(result), 64'd14);
        check("t3_div_depth", 64'(depth), 64'd1);
        send_seq('{4'h3, 4'hE, 4'h5, 4'hB});
        check("t3_sub_wrap", 64'(result), 64'hFFFF_FFFE);
        check("t3_sub_depth", 64'(depth), 64'd2);

        // multiply, add, then operator without pending operand
        send_seq('{4'hF, 4'h6, 4'hE, 4'h7, 4'hC});
        check("mul_result", 64'(result), 64'd42);
        send_seq('{4'h4, 4'hE, 4'h5, 4'hA});
        check("add_result", 64'(result), 64'd9);
        check("add_depth", 64'(depth), 64'd2);
        send_seq('{4'hA});
        check("add2_latency", 64'(rv_cyc - acc_cyc), 64'd2);
        check("add2_result", 64'(result), 64'd51);
        check("add2_depth", 64'(depth), 64'd1);

        // 4: divide by zero, ignored token in error, clear
        send_seq('{4'hF, 4'h8, 4'hE, 4'h0, 4'hD});
        check("t4_err", 64'(err), 64'd1);
        check("t4_code", 64'(err_code), 64'd3);
        check("t4_depth", 64'(depth), 64'd2);
        check("t4_result", 64'(result), 64'd0);
        send_seq('{4'h5});
        check("t4_ignored_res", 64'(result), 64'd0);
        check("t4_ignored_err", 64'(err), 64'd1);
        check("t4_ignored_dep", 64'(depth), 64'd2);
        send_seq('{4'hF});
        check("t4_clr_err", 64'(err), 64'd0);
        check("t4_clr_depth", 64'(depth), 64'd0);

        // 5: overflow on the DEPTH+1'th enter, underflow on lone ADD
        send(4'hF);
        for (int i = 0; i < DEPTH + 1; i++) send(4'hE);
        wait_idle();
        check("t5_ovf_err", 64'(err), 64'd1);
        check("t5_ovf_code", 64'(err_code), 64'd1);
        check("t5_ovf_depth", 64'(depth), 64'(DEPTH));
        send_seq('{4'hA});
        check("t5_sticky_code", 64'(err_code), 64'd1);
        send_seq('{4'hF, 4'h1, 4'hE, 4'hA});
        check("t5_udf_code", 64'(err_code), 64'd2);
        check("t5_udf_depth", 64'(depth), 64'd1);
        check("t5_udf_result", 64'(result), 64'd1);

        // 6: reset while the divider is running
        send_seq('{4'hF});
        send(4'h9);
        send(4'hE);
        send(4'h3);
        send(4'hD);
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("t6_busy", 64'(tok_ready), 64'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("t6_rst_ready", 64'(tok_ready), 64'd1);
        check("t6_rst_depth", 64'(depth), 64'd0);
        check("t6_rst_result", 64'(result), 64'd0);
        @(negedge clk);
        reset    = 1'b1;
        rv_count = 0;
        repeat (WIDTH + 6) @(posedge clk);
        #1;
        check("t6_no_stale_rv", 64'(rv_count), 64'd0);
        check("t6_idle_depth", 64'(depth), 64'd0);
        send_seq('{4'h2, 4'hE, 4'h3, 4'hC});
        check("t6_new_mul", 64'(result), 64'd6);
        check("t6_new_depth", 64'(depth), 64'd1);
        send_seq('{4'h2, 4'hD});
        check("t6_new_div", 64'(result), 64'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
